rtc_reg_arb: RTL and testbench

//  Two-requester arbiter in front of the RTC register slave (reg_cs/addr/wdata/be/wr -> rdata/ack).

---
 rtl/rtc_reg_arb.sv | 216 +++++++++++++++++++++
 tb/tb_rtc_reg_arb.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_reg_arb.sv
// Two-port round-robin arbiter in front of the RTC register slave.
// It holds a lock for atomic register pairs and completes an access with an error if the slave never acks.
module rtc_reg_arb #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_DEAD
) (
  input  logic        rtc_clk,
  input  logic        rst,
  input  logic        m0_cs,
  input  logic [4:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  input  logic        m0_wr,
  input  logic        m0_lock,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cs,
  input  logic [4:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  input  logic        m1_wr,
  input  logic        m1_lock,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        reg_cs,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          owner_r;
  logic          last_ptr_r;
  logic          lock_r;
  logic          abandon_r;
  logic [CW-1:0] cnt_r;

  logic          owner_cs_s;
  logic          cnt_last_s;
  logic          grant_s;
  logic          sel_s;
  logic          finish_s;
  logic          tmo_s;
  logic          release_s;
  logic          deliver_s;
  logic [4:0]    sel_addr_s;
  logic [31:0]   sel_wdata_s;
  logic [3:0]    sel_be_s;
  logic          sel_wr_s;
  logic          sel_lock_s;
  logic [31:0]   rsp_data_s;

  // State register.
  always_ff @(posedge rtc_clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_nxt_s = ST_ACCESS;
        else         state_nxt_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (finish_s) state_nxt_s = ST_RESP;
        else          state_nxt_s = ST_ACCESS;
      end
      ST_RESP: begin
        if (lock_r) state_nxt_s = ST_LOCKED;
        else        state_nxt_s = ST_IDLE;
      end
      ST_LOCKED: begin
        if (grant_s)        state_nxt_s = ST_ACCESS;
        else if (release_s) state_nxt_s = ST_IDLE;
        else                state_nxt_s = ST_LOCKED;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Grant, completion and response decode feeding the registered outputs.
  always_comb begin
    owner_cs_s = owner_r ? m1_cs : m0_cs;
    cnt_last_s = (cnt_r == CNT_LAST);
    grant_s    = 1'b0;
    sel_s      = 1'b0;
    finish_s   = 1'b0;
    tmo_s      = 1'b0;
    release_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        grant_s = m0_cs | m1_cs;
        // On a tie the port that did not win last time goes first.
        if (m0_cs && m1_cs) sel_s = ~last_ptr_r;
        else                sel_s = m1_cs;
      end
      ST_ACCESS: begin
        // A slave ack on the expiry cycle still wins over the timeout.
        finish_s = reg_ack | cnt_last_s;
        tmo_s    = ~reg_ack & cnt_last_s;
      end
      ST_RESP: begin
        grant_s = 1'b0;
      end
      ST_LOCKED: begin
        grant_s   = owner_cs_s;
        sel_s     = owner_r;
        release_s = ~owner_cs_s & cnt_last_s;
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase

    if (sel_s) begin
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_be_s    = m1_be;
      sel_wr_s    = m1_wr;
      sel_lock_s  = m1_lock;
    end else begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_be_s    = m0_be;
      sel_wr_s    = m0_wr;
      sel_lock_s  = m0_lock;
    end

    deliver_s = finish_s & owner_cs_s & ~abandon_r;

    if (tmo_s)       rsp_data_s = ERR_DATA;
    else if (reg_wr) rsp_data_s = 32'h0000_0000;
    else             rsp_data_s = reg_rdata;
  end

  // Slave-side request registers, response registers and timeout/idle counter.
  always_ff @(posedge rtc_clk) begin
    if (rst) begin
      reg_cs     <= 1'b0;
      reg_addr   <= 5'h00;
      reg_wdata  <= 32'h0000_0000;
      reg_be     <= 4'h0;
      reg_wr     <= 1'b0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_rdata   <= 32'h0000_0000;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_rdata   <= 32'h0000_0000;
      owner_r    <= 1'b0;
      last_ptr_r <= 1'b1;
      lock_r     <= 1'b0;
      abandon_r  <= 1'b0;
      cnt_r      <= {CW{1'b0}};
    end else begin
      m0_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_ack <= 1'b0;
      m1_err <= 1'b0;
      if (grant_s) begin
        reg_cs    <= 1'b1;
        reg_addr  <= sel_addr_s;
        reg_wdata <= sel_wdata_s;
        reg_be    <= sel_be_s;
        reg_wr    <= sel_wr_s;
        owner_r   <= sel_s;
        lock_r    <= sel_lock_s;
        abandon_r <= 1'b0;
        cnt_r     <= {CW{1'b0}};
        if (state_r == ST_IDLE) last_ptr_r <= sel_s;
      end else if (finish_s) begin
        reg_cs <= 1'b0;
        if (deliver_s && owner_r) begin
          m1_ack   <= 1'b1;
          m1_err   <= tmo_s;
          m1_rdata <= rsp_data_s;
        end else if (deliver_s) begin
          m0_ack   <= 1'b1;
          m0_err   <= tmo_s;
          m0_rdata <= rsp_data_s;
        end
      end else if (state_r == ST_ACCESS || state_r == ST_LOCKED) begin
        if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
        // An owner that drops cs mid-access loses its ack.
        if (state_r == ST_ACCESS && !owner_cs_s) abandon_r <= 1'b1;
      end else if (state_r == ST_RESP) begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_rtc_reg_arb.sv
// Directed bench for rtc_reg_arb: single-access vector table plus
// tie-break, lock, lock-release, abandoned-request and mid-access reset sequences.
module tb_rtc_reg_arb;

  logic        rtc_clk;
  logic        rst;
  logic        m0_cs, m0_wr, m0_lock, m0_ack, m0_err;
  logic [4:0]  m0_addr;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_cs, m1_wr, m1_lock, m1_ack, m1_err;
  logic [4:0]  m1_addr;
  logic [31:0] m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic        reg_cs, reg_wr, reg_ack;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic [3:0]  reg_be;

  rtc_reg_arb #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_DEAD)) dut (
    .rtc_clk(rtc_clk), .rst(rst),
    .m0_cs(m0_cs), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cs(m1_cs), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_wr(reg_wr), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  initial begin
    rtc_clk = 1'b0;
    forever #5 rtc_clk = ~rtc_clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Slave model: acks slv_lat cycles after reg_cs is first seen high (0 = never).
  int          slv_lat = 0;
  int          slv_cnt = 0;
  logic [31:0] slv_data = 32'h0;
  logic [4:0]  slv_addr = 5'h0;

  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    forever begin
      @(posedge rtc_clk);
      #1;
      if (reg_ack) begin
        reg_ack = 1'b0;
        slv_cnt = 0;
      end else if (reg_cs && slv_lat != 0) begin
        slv_cnt++;
        if (slv_cnt == slv_lat) begin
          reg_ack   = 1'b1;
          reg_rdata = slv_data;
          slv_addr  = reg_addr;
        end
      end else begin
        slv_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [4:0]  cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_wr;

  task automatic set_req(input int p, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic w, input logic l);
    if (p == 1) begin
      m1_cs = 1'b1; m1_addr = a; m1_wdata = d; m1_be = b; m1_wr = w; m1_lock = l;
    end else begin
      m0_cs = 1'b1; m0_addr = a; m0_wdata = d; m0_be = b; m0_wr = w; m0_lock = l;
    end
  endtask

  task automatic drop(input int p);
    if (p == 1) m1_cs = 1'b0;
    else        m0_cs = 1'b0;
  endtask

  // Waits up to bound edges for an ack; port=-1 if none. Counts reg_cs-high samples.
  task automatic wait_ack(input int bound, output int port, output int edges, output int cs_cyc);
    logic seen;
    seen   = 1'b0;
    port   = -1;
    edges  = 0;
    cs_cyc = 0;
    while (port < 0 && edges < bound) begin
      @(posedge rtc_clk);
      #1;
      edges++;
      if (reg_cs) begin
        cs_cyc++;
        if (!seen) begin
          seen = 1'b1; cap_addr = reg_addr; cap_wdata = reg_wdata; cap_be = reg_be; cap_wr = reg_wr;
        end
      end
      if (m0_ack) port = 0;
      else if (m1_ack) port = 1;
    end
  endtask

  typedef struct {
    int          port;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    int          lat;
    logic [31:0] sdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cs;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p, e, c, n, nack;
    logic [31:0] rd;

    // Expected reg_cs-high cycles equal the slave latency, or 16 on timeout;
    // the ack appears one edge after the last reg_cs-high sample.
    vecs[0] = '{0, 5'h00, 32'h0000_0000, 4'hF, 1'b0, 3,  32'h1234_5678, 32'h1234_5678, 1'b0, 3};
    vecs[1] = '{1, 5'h05, 32'h0000_0000, 4'hF, 1'b0, 1,  32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1};
    vecs[2] = '{0, 5'h04, 32'hCAFE_F00D, 4'hF, 1'b1, 2,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2};
    vecs[3] = '{1, 5'h1F, 32'h0123_4567, 4'h5, 1'b1, 5,  32'h5555_5555, 32'h0000_0000, 1'b0, 5};
    vecs[4] = '{0, 5'h0A, 32'h0000_0000, 4'h3, 1'b0, 0,  32'h0000_0000, 32'hDEAD_DEAD, 1'b1, 16};
    vecs[5] = '{1, 5'h11, 32'h0000_0000, 4'hF, 1'b0, 16, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 16};
    vecs[6] = '{0, 5'h12, 32'h0000_0000, 4'hC, 1'b0, 15, 32'h7654_3210, 32'h7654_3210, 1'b0, 15};

    rst = 1'b1;
    m0_cs = 1'b0; m0_addr = 5'h0; m0_wdata = 32'h0; m0_be = 4'h0; m0_wr = 1'b0; m0_lock = 1'b0;
    m1_cs = 1'b0; m1_addr = 5'h0; m1_wdata = 32'h0; m1_be = 4'h0; m1_wr = 1'b0; m1_lock = 1'b0;
    repeat (3) @(posedge rtc_clk);
    #1;
    check("reset reg_cs", {31'h0, reg_cs}, 32'h0);
    check("reset reg_addr", {27'h0, reg_addr}, 32'h0);
    check("reset acks", {30'h0, m1_ack, m0_ack}, 32'h0);
    check("reset errs", {30'h0, m1_err, m0_err}, 32'h0);
    check("reset m0_rdata", m0_rdata, 32'h0);
    check("reset m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;
    @(posedge rtc_clk);
    #1;

    // Tie after reset: M0 first; M0 re-requests while M1 waits, so M1 goes next, then M0.
    slv_lat = 2; slv_data = 32'h0000_00A0;
    set_req(0, 5'h01, 32'h0, 4'hF, 1'b0, 1'b0);
    set_req(1, 5'h02, 32'h0, 4'hF, 1'b0, 1'b0);
    wait_ack(60, p, e, c);
    check("tie first grant", p, 32'd0);
    drop(0);
    @(posedge rtc_clk);
    #1;
    set_req(0, 5'h01, 32'h0, 4'hF, 1'b0, 1'b0);
    wait_ack(60, p, e, c);
    check("tie second grant", p, 32'd1);
    drop(1);
    wait_ack(60, p, e, c);
    check("tie third grant", p, 32'd0);
    drop(0);
    @(posedge rtc_clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      slv_lat  = vecs[i].lat;
      slv_data = vecs[i].sdata;
      set_req(vecs[i].port, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].wr, 1'b0);
      wait_ack(40, p, e, c);
      rd = (vecs[i].port == 1) ? m1_rdata : m0_rdata;
      check($sformatf("v%0d ack port", i), p, vecs[i].port);
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'h0, (vecs[i].port == 1) ? m1_err : m0_err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d reg_cs cycles", i), c, vecs[i].exp_cs);
      check($sformatf("v%0d ack latency", i), e, vecs[i].exp_cs + 1);
      check($sformatf("v%0d reg_addr", i), {27'h0, cap_addr}, {27'h0, vecs[i].addr});
      check($sformatf("v%0d reg_wdata", i), cap_wdata, vecs[i].wdata);
      check($sformatf("v%0d reg_be/wr", i), {27'h0, cap_be, cap_wr}, {27'h0, vecs[i].be, vecs[i].wr});
      drop(vecs[i].port);
      @(posedge rtc_clk);
      #1;
      check($sformatf("v%0d ack pulse", i), {30'h0, m1_ack, m0_ack}, 32'h0);
      check($sformatf("v%0d rdata hold", i), (vecs[i].port == 1) ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
    end

    // Locked pair from M1 keeps M0 waiting until the unlocked access finishes.
    slv_lat = 2; slv_data = 32'h0000_0001;
    set_req(1, 5'h00, 32'h1111_1111, 4'hF, 1'b1, 1'b1);
    @(posedge rtc_clk);
    #1;
    set_req(0, 5'h10, 32'h0, 4'hF, 1'b0, 1'b0);
    wait_ack(60, p, e, c);
    check("lock first port", p, 32'd1);
    check("lock first addr", {27'h0, slv_addr}, 32'h00);
    drop(1);
    @(posedge rtc_clk);
    #1;
    set_req(1, 5'h04, 32'h2222_2222, 4'hF, 1'b1, 1'b0);
    wait_ack(60, p, e, c);
    check("lock second port", p, 32'd1);
    check("lock second addr", {27'h0, slv_addr}, 32'h04);
    drop(1);
    wait_ack(60, p, e, c);
    check("lock waiter port", p, 32'd0);
    check("lock waiter addr", {27'h0, slv_addr}, 32'h10);
    drop(0);
    @(posedge rtc_clk);
    #1;

    // M0 locks then goes idle: 16 LOCKED cycles, then IDLE grants the pending M1.
    set_req(0, 5'h02, 32'h0, 4'hF, 1'b0, 1'b1);
    @(posedge rtc_clk);
    #1;
    set_req(1, 5'h03, 32'h0, 4'hF, 1'b0, 1'b0);
    wait_ack(60, p, e, c);
    check("release owner ack", p, 32'd0);
    drop(0);
    n = 0; nack = 0;
    while (n < 40) begin
      @(posedge rtc_clk);
      #1;
      n++;
      if (m0_ack || m1_ack) nack++;
      if (reg_cs) break;
    end
    check("release delay", n, 32'd18);
    check("release no ack", nack, 32'd0);
    check("release grant addr", {27'h0, reg_addr}, 32'h03);
    wait_ack(60, p, e, c);
    check("release M1 ack", p, 32'd1);
    drop(1);
    @(posedge rtc_clk);
    #1;

    // M0 drops cs mid-access: the slave access completes, no ack is returned.
    slv_lat = 4;
    set_req(0, 5'h06, 32'h0, 4'hF, 1'b0, 1'b0);
    repeat (2) @(posedge rtc_clk);
    #1;
    drop(0);
    wait_ack(12, p, e, c);
    check("abandon no ack", p, 32'hFFFF_FFFF);
    check("abandon reg_cs cycles", c, 32'd2);

    // Reset during ACCESS aborts; next tie arbitrates from the reset pointer (M0 first).
    slv_lat = 0;
    set_req(0, 5'h07, 32'h0, 4'hF, 1'b0, 1'b0);
    repeat (4) @(posedge rtc_clk);
    #1;
    check("pre-reset reg_cs", {31'h0, reg_cs}, 32'h1);
    rst = 1'b1;
    drop(0);
    @(posedge rtc_clk);
    #1;
    check("reset abort reg_cs", {31'h0, reg_cs}, 32'h0);
    rst = 1'b0;
    wait_ack(20, p, e, c);
    check("reset abort no ack", p, 32'hFFFF_FFFF);
    check("reset m0_rdata cleared", m0_rdata, 32'h0);
    slv_lat = 2; slv_data = 32'h0000_0042;
    set_req(0, 5'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    set_req(1, 5'h09, 32'h0, 4'hF, 1'b0, 1'b0);
    wait_ack(60, p, e, c);
    check("post-reset first grant", p, 32'd0);
    check("post-reset m0_rdata", m0_rdata, 32'h0000_0042);
    drop(0);
    wait_ack(60, p, e, c);
    check("post-reset second grant", p, 32'd1);
    drop(1);
    @(posedge rtc_clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
